// File: rtl/datapath_sequencer_pkg.sv
// Shared encodings for the datapath sequencer: ALU ops, operand-B shifts, FSM states
// and the command fields latched when an operation is accepted.
package datapath_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_AND  = 2'b10,
    OP_NOTB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WRITE  = 3'd4
  } state_e;

  typedef struct packed {
    op_e        op;
    shift_e     shift;
    logic [2:0] rn;
    logic [2:0] rm;
    logic [2:0] rd;
  } cmd_t;

endpackage

// File: rtl/datapath_sequencer_if.sv
// Command, register-file and status signals between the sequencer (slave) and its
// environment (master); no backpressure, start is simply ignored while busy.
interface datapath_sequencer_if #(parameter int WIDTH = 16);
  logic             start;
  logic [1:0]       op;
  logic [1:0]       shift;
  logic [2:0]       rn;
  logic [2:0]       rm;
  logic [2:0]       rd;
  logic [2:0]       readnum;
  logic [WIDTH-1:0] data_out;
  logic [2:0]       writenum;
  logic             write;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic             z;

  modport master (
    output start, op, shift, rn, rm, rd, data_out,
    input  readnum, writenum, write, data_in, busy, done, z
  );

  modport slave (
    input  start, op, shift, rn, rm, rd, data_out,
    output readnum, writenum, write, data_in, busy, done, z
  );
endinterface

// File: rtl/Regfile.sv
// Eight-entry register file: synchronous write, combinational read on readnum.
module Regfile #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             write,
  input  logic [2:0]       writenum,
  input  logic [WIDTH-1:0] data_in,
  input  logic [2:0]       readnum,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] regs [8];

  always_ff @(posedge clk) begin
    if (write) begin
      regs[writenum] <= data_in;
    end
  end

  assign data_out = regs[readnum];

endmodule

// File: rtl/alu_shift.sv
// Combinational shifter on operand B feeding a 4-function ALU; zero flags an all-zero result.
module alu_shift
  import datapath_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  input  shift_e           shift,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  logic [WIDTH-1:0] b_sh;

  always_comb begin
    b_sh = b;
    case (shift)
      SH_NONE: b_sh = b;
      SH_LSL:  b_sh = {b[WIDTH-2:0], 1'b0};
      SH_LSR:  b_sh = {1'b0, b[WIDTH-1:1]};
      SH_ASR:  b_sh = {b[WIDTH-1], b[WIDTH-1:1]};
      default: b_sh = b;
    endcase
  end

  // ADD/SUB deliberately drop the carry: results wrap modulo 2^WIDTH.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b_sh;
      OP_SUB:  result = a - b_sh;
      OP_AND:  result = a & b_sh;
      OP_NOTB: result = ~b_sh;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/dff_r.sv
// Enabled register with synchronous active-high clear; reset wins over enable.
module dff_r #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Five-state sequencer: read A, read B, execute, write back; 4 cycles from accepted start to
// register-file update. start is accepted only in IDLE and dropped (never queued) while busy.
module datapath_sequencer
  import datapath_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  datapath_sequencer_if.slave  bus
);

  state_e           state;
  state_e           next_state;
  logic [2:0]       state_q;
  cmd_t             cmd_in;
  cmd_t             cmd_q;
  logic             accept;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             z_q;

  assign state  = state_e'(state_q);
  assign accept = (state == S_IDLE) && bus.start;

  assign cmd_in = '{op:    op_e'(bus.op),
                    shift: shift_e'(bus.shift),
                    rn:    bus.rn,
                    rm:    bus.rm,
                    rd:    bus.rd};

  dff_r #(.W(3)) u_state_reg (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (next_state),
    .q     (state_q)
  );

  // Command fields are frozen at acceptance so input changes mid-operation are harmless.
  dff_r #(.W($bits(cmd_t))) u_cmd_reg (
    .clk   (clk),
    .reset (reset),
    .en    (accept),
    .d     (cmd_in),
    .q     (cmd_q)
  );

  dff_r #(.W(WIDTH)) u_a_reg (
    .clk   (clk),
    .reset (reset),
    .en    (state == S_LOAD_A),
    .d     (bus.data_out),
    .q     (a_q)
  );

  dff_r #(.W(WIDTH)) u_b_reg (
    .clk   (clk),
    .reset (reset),
    .en    (state == S_LOAD_B),
    .d     (bus.data_out),
    .q     (b_q)
  );

  dff_r #(.W(WIDTH)) u_c_reg (
    .clk   (clk),
    .reset (reset),
    .en    (state == S_EXEC),
    .d     (result),
    .q     (c_q)
  );

  dff_r #(.W(1)) u_z_reg (
    .clk   (clk),
    .reset (reset),
    .en    (state == S_EXEC),
    .d     (zero),
    .q     (z_q)
  );

  alu_shift #(.WIDTH(WIDTH)) u_alu_shift (
    .a      (a_q),
    .b      (b_q),
    .op     (cmd_q.op),
    .shift  (cmd_q.shift),
    .result (result),
    .zero   (zero)
  );

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (bus.start) next_state = S_LOAD_A;
      S_LOAD_A: next_state = S_LOAD_B;
      S_LOAD_B: next_state = S_EXEC;
      S_EXEC:   next_state = S_WRITE;
      S_WRITE:  next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.readnum = 3'd0;
    case (state)
      S_LOAD_A: bus.readnum = cmd_q.rn;
      S_LOAD_B: bus.readnum = cmd_q.rm;
      default:  bus.readnum = 3'd0;
    endcase
  end

  // Gating with reset keeps a reset raised during WRITE from committing the result.
  assign bus.write    = (state == S_WRITE) && !reset;
  assign bus.writenum = cmd_q.rd;
  assign bus.data_in  = c_q;
  assign bus.done     = (state == S_WRITE);
  assign bus.busy     = (state != S_IDLE);
  assign bus.z        = z_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Sequencer wired to a Regfile; expected writebacks are queued at issue and matched on write.
module tb_datapath_sequencer;

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] val;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        pl_en;
  logic [2:0]  pl_num;
  logic [15:0] pl_dat;
  logic        rf_we;
  logic [2:0]  rf_wn;
  logic [15:0] rf_wd;
  logic [15:0] model [8];
  logic [15:0] init_vals [8];
  exp_t        sbq [$];
  int          vectors = 0;
  int          miscompares = 0;
  int          writes = 0;
  int          w0;

  datapath_sequencer_if #(.WIDTH(16)) bus ();

  datapath_sequencer #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign rf_we = pl_en | bus.write;
  assign rf_wn = pl_en ? pl_num : bus.writenum;
  assign rf_wd = pl_en ? pl_dat : bus.data_in;

  Regfile #(.WIDTH(16)) rf (
    .clk      (clk),
    .write    (rf_we),
    .writenum (rf_wn),
    .data_in  (rf_wd),
    .readnum  (bus.readnum),
    .data_out (bus.data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_alu(input logic [1:0] o, input logic [1:0] s,
                                          input logic [15:0] a, input logic [15:0] b);
    logic [15:0]        sb;
    logic signed [15:0] bsg;
    bsg = b;
    case (s)
      2'd0:    sb = b;
      2'd1:    sb = b << 1;
      2'd2:    sb = b >> 1;
      default: sb = 16'(bsg >>> 1);
    endcase
    case (o)
      2'd0:    return a + sb;
      2'd1:    return a - sb;
      2'd2:    return a & sb;
      default: return ~sb;
    endcase
  endfunction

  always @(negedge clk) begin
    if (bus.write) begin
      exp_t e;
      writes++;
      if (sbq.size() == 0) begin
        chk("spurious_write", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("wr_num", 32'(bus.writenum), 32'(e.rd));
        chk("wr_dat", 32'(bus.data_in), 32'(e.val));
        chk("wr_z", 32'(bus.z), 32'(e.z));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [1:0] s,
                       input logic [2:0] n, input logic [2:0] m, input logic [2:0] d);
    bus.start = 1'b1;
    bus.op    = o;
    bus.shift = s;
    bus.rn    = n;
    bus.rm    = m;
    bus.rd    = d;
  endtask

  task automatic push_exp(input logic [1:0] o, input logic [1:0] s,
                          input logic [2:0] n, input logic [2:0] m, input logic [2:0] d);
    exp_t e;
    e.rd  = d;
    e.val = ref_alu(o, s, model[n], model[m]);
    e.z   = (e.val == 16'd0);
    sbq.push_back(e);
    model[d] = e.val;
  endtask

  task automatic do_op(input logic [1:0] o, input logic [1:0] s,
                       input logic [2:0] n, input logic [2:0] m, input logic [2:0] d);
    push_exp(o, s, n, m, d);
    @(posedge clk); #1;
    issue(o, s, n, m, d);
    @(posedge clk); #1;
    // Scramble the inputs after acceptance; the latched command must be used.
    bus.start = 1'b0;
    bus.op    = 2'($urandom_range(3));
    bus.shift = 2'($urandom_range(3));
    bus.rn    = 3'($urandom_range(7));
    bus.rm    = 3'($urandom_range(7));
    bus.rd    = 3'($urandom_range(7));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("busy", 32'(bus.busy), 32'd1);
      chk("done", 32'(bus.done), (k == 4) ? 32'd1 : 32'd0);
      if (k == 1) chk("readnum_a", 32'(bus.readnum), 32'(n));
      if (k == 2) chk("readnum_b", 32'(bus.readnum), 32'(m));
    end
    @(negedge clk);
    chk("busy_after", 32'(bus.busy), 32'd0);
    chk("done_after", 32'(bus.done), 32'd0);
    chk("rf_value", 32'(rf.regs[d]), 32'(model[d]));
  endtask

  initial begin
    init_vals = '{16'd20, 16'd3, 16'd0, 16'd0, 16'h8000, 16'd0, 16'd0, 16'd42};
    reset  = 1'b1;
    pl_en  = 1'b1;
    pl_num = 3'd0;
    pl_dat = 16'd0;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.shift = 2'd0;
    bus.rn    = 3'd0;
    bus.rm    = 3'd0;
    bus.rd    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      pl_num = 3'(i);
      pl_dat = init_vals[i];
      model[i] = init_vals[i];
      @(posedge clk); #1;
    end
    pl_en = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_write", 32'(bus.write), 32'd0);
    chk("rst_z", 32'(bus.z), 32'd0);
    chk("rst_data_in", 32'(bus.data_in), 32'd0);
    chk("rst_readnum", 32'(bus.readnum), 32'd0);
    chk("rst_writenum", 32'(bus.writenum), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.start = 1'b0;

    do_op(2'b00, 2'b00, 3'd0, 3'd1, 3'd2);
    chk("add_r2_23", 32'(rf.regs[2]), 32'd23);
    do_op(2'b01, 2'b00, 3'd1, 3'd1, 3'd3);
    chk("sub_z", 32'(bus.z), 32'd1);
    chk("sub_r3_0", 32'(rf.regs[3]), 32'd0);
    do_op(2'b00, 2'b01, 3'd7, 3'd1, 3'd7);
    chk("add_lsl_r7_48", 32'(rf.regs[7]), 32'd48);
    do_op(2'b11, 2'b11, 3'd0, 3'd4, 3'd5);
    chk("notb_asr_3fff", 32'(rf.regs[5]), 32'h3FFF);
    do_op(2'b10, 2'b10, 3'd0, 3'd1, 3'd6);
    do_op(2'b01, 2'b00, 3'd1, 3'd0, 3'd6);
    chk("sub_wrap_ffef", 32'(rf.regs[6]), 32'hFFEF);

    // start held high through busy: one write only
    w0 = writes;
    push_exp(2'b00, 2'b00, 3'd7, 3'd0, 3'd2);
    @(posedge clk); #1;
    issue(2'b00, 2'b00, 3'd7, 3'd0, 3'd2);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold_one_write", 32'(writes - w0), 32'd1);
    chk("hold_r2_68", 32'(rf.regs[2]), 32'd68);
    chk("hold_idle", 32'(bus.busy), 32'd0);

    // reset during EXEC aborts without a write
    w0 = writes;
    @(posedge clk); #1;
    issue(2'b00, 2'b00, 3'd0, 3'd1, 3'd2);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("exec_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_write", 32'(bus.write), 32'd0);
    chk("abort_data_in", 32'(bus.data_in), 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_no_write", 32'(writes - w0), 32'd0);
    chk("abort_r2_kept", 32'(rf.regs[2]), 32'd68);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
